// File: rtl/dma_dreq_requester.sv
// Peripheral-side DMA requester: drives one DREQ bit, counts DACK transfers, ends on count or EOP.
// Optional REQUEST watchdog is enabled by defining DREQ_TIMEOUT_EN.
module dma_dreq_requester #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CNT_W-1:0] XferCount,
    input  logic             DemandMode,
    input  logic             SenseDreq,
    input  logic             SenseDack,
    input  logic             Dack,
    input  logic             Eop_n,
    output logic             Dreq,
    output logic             Busy,
    output logic             Done,
    output logic             Terminated,
    output logic             TimeoutErr,
    output logic [CNT_W-1:0] Remaining,
    output logic [2:0]       StateDbg
);

    // Handshake: Dreq is a level request held until this channel's DACK rises;
    // each DACK rising edge (after polarity correction) is one completed transfer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        ACKED   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             dreq_q, dreq_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             demand_q, demand_d;
    logic             term_q, term_d;
    logic             dack_act_q;
    logic             dack_act;
    logic             dack_rise;
    logic             eop;
    logic             timeout_hit;

    assign dack_act  = Dack ~^ SenseDack;
    assign dack_rise = dack_act & ~dack_act_q;
    assign eop       = ~Eop_n;

`ifdef DREQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              tout_q;

    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_q <= '0;
            tout_q <= 1'b0;
        end else begin
            if (state_q == REQUEST && state_d == REQUEST)
                wait_q <= wait_q + 1'b1;
            else
                wait_q <= '0;
            if (state_q == IDLE && Start)
                tout_q <= 1'b0;
            else if (state_q == REQUEST && !eop && !dack_rise && timeout_hit)
                tout_q <= 1'b1;
        end
    end

    assign TimeoutErr = tout_q;
`else
    assign timeout_hit = 1'b0;
    // Watchdog compiled out: the flag is a constant zero.
    assign TimeoutErr  = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        dreq_d      = 1'b0;
        remaining_d = remaining_q;
        demand_d    = demand_q;
        term_d      = term_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    remaining_d = XferCount;
                    demand_d    = DemandMode;
                    term_d      = 1'b0;
                    state_d     = (XferCount == '0) ? DONE : REQUEST;
                end
            end
            REQUEST: begin
                // A transfer acknowledged on the EOP edge still counts.
                if (dack_rise && remaining_q != '0)
                    remaining_d = remaining_q - 1'b1;
                if (eop) begin
                    term_d  = 1'b1;
                    state_d = DONE;
                end else if (dack_rise) begin
                    if (remaining_q <= CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACKED;
                        dreq_d  = demand_q;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end else begin
                    dreq_d = 1'b1;
                end
            end
            ACKED: begin
                if (eop) begin
                    term_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dreq_d = demand_q;
                    if (!dack_act)
                        state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (eop) begin
                    term_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dreq_d  = demand_q;
                    state_d = REQUEST;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            dreq_q      <= 1'b0;
            remaining_q <= '0;
            demand_q    <= 1'b0;
            term_q      <= 1'b0;
            dack_act_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dreq_q      <= dreq_d;
            remaining_q <= remaining_d;
            demand_q    <= demand_d;
            term_q      <= term_d;
            dack_act_q  <= dack_act;
        end
    end

    assign Dreq       = dreq_q ^ SenseDreq;
    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == DONE);
    assign Terminated = term_q;
    assign Remaining  = remaining_q;
    assign StateDbg   = state_q;

endmodule

// File: tb/tb_dma_dreq_requester.sv
// Bench for dma_dreq_requester: job-level reference model feeding an expected queue, randomized DACK/EOP controller.
module tb_dma_dreq_requester;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int W       = CNT_W + 5;
`ifdef DREQ_TIMEOUT_EN
    localparam bit TOUT_ON = 1'b1;
`else
    localparam bit TOUT_ON = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_ACK  = 2;
    localparam int P_REL  = 3;
    localparam int P_DONE = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [CNT_W-1:0] XferCount = '0;
    logic             DemandMode = 1'b0;
    logic             SenseDreq = 1'b0;
    logic             SenseDack = 1'b1;
    logic             Dack = 1'b0;
    logic             Eop_n = 1'b1;
    logic             Dreq;
    logic             Busy;
    logic             Done;
    logic             Terminated;
    logic             TimeoutErr;
    logic [CNT_W-1:0] Remaining;
    logic [2:0]       StateDbg;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    int done_seen     = 0;
    int dreq_falls    = 0;
    int dreq_act_seen = 0;
    bit prev_act      = 1'b0;

    dma_dreq_requester #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .XferCount(XferCount),
        .DemandMode(DemandMode), .SenseDreq(SenseDreq), .SenseDack(SenseDack),
        .Dack(Dack), .Eop_n(Eop_n), .Dreq(Dreq), .Busy(Busy), .Done(Done),
        .Terminated(Terminated), .TimeoutErr(TimeoutErr), .Remaining(Remaining),
        .StateDbg(StateDbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL sim_watchdog: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- reference model ----------------
    // A job is a sequence of phases; Dreq is active in a demand job on every
    // cycle after its first, and in a single job on every REQUEST cycle except
    // the first one of each visit.
    int               m_phase = P_IDLE;
    int               m_age   = 0;
    int               m_visit = 0;
    logic [CNT_W-1:0] m_rem   = '0;
    bit               m_demand = 1'b0;
    bit               m_term  = 1'b0;
    bit               m_tout  = 1'b0;
    bit               m_dack_q = 1'b0;

    always @(posedge Clock) begin : model
        bit act;
        bit rise;
        bit eop;
        bit lvl;
        int nxt;
        act  = SenseDack ? Dack : ~Dack;
        rise = act && !m_dack_q;
        eop  = !Eop_n;
        if (Reset) begin
            m_phase = P_IDLE; m_age = 0; m_visit = 0; m_rem = '0;
            m_demand = 1'b0; m_term = 1'b0; m_tout = 1'b0; m_dack_q = 1'b0;
        end else begin
            if (m_phase == P_IDLE) begin
                if (Start) begin
                    m_rem = XferCount; m_demand = DemandMode;
                    m_term = 1'b0; m_tout = 1'b0; m_age = 0; m_visit = 0;
                    m_phase = (XferCount == 0) ? P_DONE : P_REQ;
                end
            end else if (m_phase == P_DONE) begin
                m_phase = P_IDLE;
            end else begin
                nxt = m_phase;
                if (m_phase == P_REQ && rise && m_rem != 0) m_rem = m_rem - 1;
                if (eop) begin
                    m_term = 1'b1; nxt = P_DONE;
                end else if (m_phase == P_REQ) begin
                    if (rise) nxt = (m_rem == 0) ? P_DONE : P_ACK;
                    else if (TOUT_ON && m_visit == TIMEOUT - 1) begin
                        m_tout = 1'b1; nxt = P_DONE;
                    end
                end else if (m_phase == P_ACK) begin
                    if (!act) nxt = P_REL;
                end else begin
                    nxt = P_REQ;
                end
                m_visit = (m_phase == P_REQ && nxt == P_REQ) ? m_visit + 1 : 0;
                m_age = m_age + 1;
                m_phase = nxt;
            end
            m_dack_q = act;
        end
        lvl = (m_phase == P_REQ || m_phase == P_ACK || m_phase == P_REL) &&
              (m_demand ? (m_age > 0) : (m_phase == P_REQ && m_visit > 0));
        exp_q.push_back({lvl, m_phase != P_IDLE, m_phase == P_DONE, m_term, m_tout, m_rem});
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge Clock) begin : compare
        logic [W-1:0] e;
        bit cur_act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dreq",       32'(Dreq),       32'(e[W-1] ^ SenseDreq));
            check("busy",       32'(Busy),       32'(e[W-2]));
            check("done",       32'(Done),       32'(e[W-3]));
            check("terminated", 32'(Terminated), 32'(e[W-4]));
            check("timeouterr", 32'(TimeoutErr), 32'(e[W-5]));
            check("remaining",  32'(Remaining),  32'(e[CNT_W-1:0]));
        end
        cur_act = (Dreq ^ SenseDreq) === 1'b1;
        if (Done === 1'b1) done_seen++;
        if (cur_act) dreq_act_seen++;
        if (prev_act && !cur_act && Busy === 1'b1) dreq_falls++;
        prev_act = cur_act;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic drive_dack(input bit act);
        Dack = SenseDack ? act : ~act;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) tick();
        Reset = 1'b0;
    endtask

    task automatic set_sense(input logic sd, input logic sk);
        SenseDreq = sd;
        SenseDack = sk;
        drive_dack(1'b0);
    endtask

    task automatic start_job(input int cnt, input logic demand);
        XferCount  = CNT_W'(cnt);
        DemandMode = demand;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
    endtask

    // Controller: answers an active Dreq with a 1-3 cycle DACK after 0-2 cycles,
    // keeps DACK low at least two cycles between pulses, optional EOP.
    task automatic serve(input int budget, input int eop_ack, input int eop_rand);
        bit act;
        int hold, low, acks, since, cyc, delay;
        act = 1'b0; hold = 0; low = 2; acks = 0; since = 0; cyc = 0;
        delay = $urandom_range(0, 2);
        while (Busy === 1'b1 && cyc < budget) begin
            Eop_n = 1'b1;
            if (act) begin
                since++;
                if (eop_ack != 0 && acks == eop_ack && since == 1) Eop_n = 1'b0;
                if (since >= hold) begin
                    act = 1'b0; low = 0;
                end
            end else begin
                low++;
                if ((Dreq ^ SenseDreq) === 1'b1 && low >= 2) begin
                    if (delay == 0) begin
                        act = 1'b1; hold = $urandom_range(1, 3); since = 0; acks++;
                        delay = $urandom_range(0, 2);
                    end else begin
                        delay--;
                    end
                end
            end
            if (eop_rand != 0 && $urandom_range(0, eop_rand - 1) == 0) Eop_n = 1'b0;
            drive_dack(act);
            tick();
            cyc++;
        end
        Eop_n = 1'b1;
        drive_dack(1'b0);
        if (cyc >= budget) begin
            total++; bad++;
            $display("FAIL serve_budget: got busy after %0d cycles expected idle", cyc);
        end
        tick();
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int d0, f0, a0;
        do_reset(3);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_dreq", 32'(Dreq), 0);
        check("rst_rem",  32'(Remaining), 0);
        check("rst_term", 32'(Terminated), 0);
        check("rst_tout", 32'(TimeoutErr), 0);

        // single mode, three transfers
        d0 = done_seen; f0 = dreq_falls;
        start_job(3, 1'b0);
        check("s1_busy_after_start", 32'(Busy), 1);
        check("s1_dreq_entry", 32'(Dreq), 0);
        tick();
        check("s1_dreq_active", 32'(Dreq), 1);
        serve(200, 0, 0);
        check("s1_rem",   32'(Remaining), 0);
        check("s1_done",  32'(done_seen - d0), 1);
        check("s1_falls", 32'(dreq_falls - f0), 3);
        check("s1_busy",  32'(Busy), 0);

        // demand mode, four transfers: one drop, at job end
        d0 = done_seen; f0 = dreq_falls;
        start_job(4, 1'b1);
        serve(200, 0, 0);
        check("s2_rem",   32'(Remaining), 0);
        check("s2_falls", 32'(dreq_falls - f0), 1);
        check("s2_done",  32'(done_seen - d0), 1);

        // inverted senses
        set_sense(1'b1, 1'b0);
        tick();
        check("s3_dreq_idle", 32'(Dreq), 1);
        d0 = done_seen; f0 = dreq_falls;
        start_job(3, 1'b0);
        tick();
        check("s3_dreq_active", 32'(Dreq), 0);
        serve(200, 0, 0);
        check("s3_rem",   32'(Remaining), 0);
        check("s3_falls", 32'(dreq_falls - f0), 3);
        check("s3_done",  32'(done_seen - d0), 1);
        set_sense(1'b0, 1'b1);
        tick();

        // EOP during the second ACKED
        d0 = done_seen;
        start_job(5, 1'b0);
        serve(200, 2, 0);
        check("s4_rem",  32'(Remaining), 3);
        check("s4_term", 32'(Terminated), 1);
        check("s4_done", 32'(done_seen - d0), 1);
        check("s4_dreq", 32'(Dreq), 0);

        // no DACK at all
        d0 = done_seen;
        start_job(7, 1'b0);
        if (TOUT_ON) begin
            for (int i = 0; i < 40 && Busy === 1'b1; i++) tick();
            check("s5_tout", 32'(TimeoutErr), 1);
            check("s5_rem",  32'(Remaining), 7);
            check("s5_term", 32'(Terminated), 0);
            check("s5_done", 32'(done_seen - d0), 1);
        end else begin
            repeat (100) tick();
            check("s5_dreq_held", 32'(Dreq), 1);
            check("s5_busy", 32'(Busy), 1);
            check("s5_rem",  32'(Remaining), 7);
        end

        // reset in REQUEST
        d0 = done_seen;
        start_job(3, 1'b0);
        repeat (3) tick();
        do_reset(2);
        check("s6_busy", 32'(Busy), 0);
        check("s6_dreq", 32'(Dreq), 0);
        check("s6_rem",  32'(Remaining), 0);
        check("s6_done", 32'(done_seen - d0), 0);

        // zero-count job
        d0 = done_seen; a0 = dreq_act_seen;
        start_job(0, 1'b0);
        check("s7_done_pulse", 32'(Done), 1);
        tick();
        check("s7_busy", 32'(Busy), 0);
        tick();
        check("s7_done", 32'(done_seen - d0), 1);
        check("s7_no_dreq", 32'(dreq_act_seen - a0), 0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            set_sense(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            start_job($urandom_range(0, 6), 1'($urandom_range(0, 1)));
            serve(400, 0, ($urandom_range(0, 1) == 1) ? 30 : 0);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
